ae_seq_core: RTL and testbench
==============================

# ae_seq_core

Sequenced autoencoder compute core: parametrised fixed-point register file, program memory, ALU and activation unit, driven by an internal fetch/execute/writeback FSM. It closes the open "instruction memory" gap of the first-generation datapath. The host loads a program and operands, pulses `start`, and waits for `done`. Adds MAC, saturation, error flagging and a start/done handshake.

## Interface
- `DATA_W`, 16: data word width, signed two's complement fixed-point.
- `FRAC_W`, 8: fractional bits. 1.0 = `1<<FRAC_W`.
- `PROG_DEPTH`, 64: instruction words. Power of two, ≥2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `prog_we` in 1: program write strobe. Honoured only when not busy.
- `prog_addr` in log2(PROG_DEPTH): program write address.
- `prog_data` in 16: instruction word.
- `reg_we` in 1: host register write. Honoured only when not busy.
- `reg_addr` in 4: host register address, for write and read.
- `reg_wdata` in DATA_W: host write data.
- `reg_rdata` out DATA_W: registered read of `reg_addr`, 1-cycle latency. Valid any time.
- `start` in 1: begin execution at PC 0. Sampled only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until DONE ends.
- `done` out 1: one-cycle pulse on completion.
- `err` out 1: sticky error flag. Cleared on reset or on an accepted `start`.

## Operation
- Instruction format: [15:12] opcode, [11:8] src1, [7:4] src2, [3:0] dst. There are 16 registers R0..R15.
- Opcodes:
  - 0 NOP.
  - 1 ADD: dst=sat(src1+src2).
  - 2 SUB: dst=sat(src1−src2).
  - 3 MUL: dst=sat((src1*src2)>>>FRAC_W). Full 2·DATA_W-bit product, arithmetic shift, floor rounding.
  - 4 RELU: dst = src1<0 ? 0 : src1.
  - 5 RELUD: dst = src1>0 ? 1.0 : 0.
  - 6 SIGM: hard sigmoid. dst = clamp((src1>>>2) + (1<<(FRAC_W−1)), 0, 1<<FRAC_W).
  - 7 MAC: dst = sat(dst + ((src1*src2)>>>FRAC_W)). Product is not saturated before the add; one final saturation.
  - 8–14 illegal: set `err`, no writeback, go to DONE.
  - 15 HALT: go to DONE.
- Saturation: clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Unused fields are ignored.
- FSM states:
  - IDLE → FETCH on `start`. PC=0, `err` cleared.
  - FETCH: synchronous program read at PC, instruction registered.
  - EXEC: operands read, result computed and registered. HALT or illegal → DONE.
  - WB: register write (NOP writes nothing). Then:
    - PC==PROG_DEPTH−1 → set `err`, go to DONE (program ran off the end, no wrap).
    - Otherwise PC++ and go to FETCH.
  - DONE: `done`=1 for one cycle → IDLE.
- Source reads in EXEC see all prior WB writes. dst==src is legal.
- Host `prog_we`/`reg_we` while busy are dropped. `start` while busy is ignored.
- If `start` and `prog_we`/`reg_we` occur in the same IDLE cycle, the write lands first and start is accepted.

## Timing
- Reset values:
  - State IDLE, PC 0.
  - `busy`=0, `done`=0, `err`=0, `reg_rdata`=0.
  - Register file and program memory are not cleared.
- Reset mid-run: next cycle is IDLE with all outputs at reset values. No further writebacks. Registers keep already-written values.
- Each non-terminating instruction takes 3 cycles.
- `start` sampled at edge 0:
  - Instruction i is FETCH in cycle 3i+1, EXEC in 3i+2, WB in 3i+3.
  - If HALT is at index N, `done` is high in cycle 3N+3. `busy` is high in cycles 1..3N+3.
- Illegal opcode at index N: `done` in cycle 3N+3 with `err`=1.
- Run-off at the last address: `done` one cycle after the WB of the last address.
- `err` is valid in the `done` cycle and holds until the next accepted start or reset.
- `reg_rdata` reflects a write made in the cycle before it is sampled. A WB at edge k is visible on `reg_rdata` after edge k+1.

## Test plan
- Q8.8 arithmetic. R1=0x0180, R2=0x0200. Program MUL R3=R1*R2; ADD R4=R3+R1; HALT → R3=0x0300, R4=0x0480. `done` in cycle 9, `err`=0.
- Saturation. R1=0x7F00, R2=0x0200: ADD → 0x7FFF. R1=0x8100, SUB R1−R2 → 0x8000. MUL 0x7F00*0x7F00 → 0x7FFF.
- Activations with R1 = 0x0000 / 0x0400 / 0xFF00 / 0xFFFF:
  - SIGM → 0x0080 / 0x0100 / 0x0040 / 0x007F.
  - RELU of 0xFF00 → 0.
  - RELUD of 0x0001 → 0x0100, of 0 → 0.
- MAC chain. R5=0x0100 (1.0), R1=0x0200, R2=0x0080. MAC R5 twice → R5=0x0300 after the first and 0x0500 after the second. MAC toward overflow → 0x7FFF.
- Errors:
  - Opcode 0x9 at index 2 → `done` in cycle 9, `err`=1, no write to its dst.
  - A program with no HALT fills PROG_DEPTH → `err`=1.
  - The next `start` clears `err`.
- Control: `start`/`reg_we`/`prog_we` during busy are ignored, with registers unchanged. `reset` asserted in an EXEC cycle → next cycle `busy`=0 and the pending dst is unchanged.

Source files
------------

// File: rtl/ae_seq_core_if.sv
// Host bus for ae_seq_core: program load, register access, start/done.
// master = host side, slave = core side; clock and reset are separate ports.
interface ae_seq_core_if #(
    parameter int DATA_W     = 16,
    parameter int PROG_DEPTH = 64
);
    localparam int AW = $clog2(PROG_DEPTH);

    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [15:0]       prog_data;
    logic              reg_we;
    logic [3:0]        reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output prog_we, prog_addr, prog_data,
        output reg_we, reg_addr, reg_wdata,
        output start,
        input  reg_rdata, busy, done, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data,
        input  reg_we, reg_addr, reg_wdata,
        input  start,
        output reg_rdata, busy, done, err
    );
endinterface

// File: rtl/ae_seq_core.sv
// Sequenced fixed-point compute core: 16-entry register file, program memory,
// saturating ALU/activation unit and a fetch/exec/writeback FSM.
// Ports: clock, reset (sync, active-high), bus (ae_seq_core_if.slave).
module ae_seq_core #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int PROG_DEPTH = 64
) (
    input  logic          clock,
    input  logic          reset,
    ae_seq_core_if.slave  bus
);
    localparam int AW = $clog2(PROG_DEPTH);
    // One guard bit above the full product keeps MAC sums exact.
    localparam int PW = 2 * DATA_W + 1;
    localparam logic [AW-1:0] LAST = AW'(PROG_DEPTH - 1);

    localparam logic signed [PW-1:0] MAXV =
        {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV =
        {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0] ONE =
        {{(PW-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [PW-1:0] HALF =
        {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]       prog_mem [PROG_DEPTH];
    logic [DATA_W-1:0] rf [16];

    logic [AW-1:0]     pc_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] res_q;
    logic              wb_en_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [3:0] op, s1, s2, dst;
    assign op  = ir_q[15:12];
    assign s1  = ir_q[11:8];
    assign s2  = ir_q[7:4];
    assign dst = ir_q[3:0];

    logic halt, illegal, writes;
    assign halt    = (op == 4'hF);
    assign illegal = op[3] && !halt;
    assign writes  = !op[3] && (op != 4'h0);

    logic signed [DATA_W-1:0]   a, b, d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [PW-1:0]       a_x, b_x, d_x, prod_x, prod_sh;
    logic signed [PW-1:0]       sum, diff, mac, sig;
    logic [DATA_W-1:0]          alu;

    assign a = rf[s1];
    assign b = rf[s2];
    assign d = rf[dst];

    assign a_x    = $signed({{(PW-DATA_W){a[DATA_W-1]}}, a});
    assign b_x    = $signed({{(PW-DATA_W){b[DATA_W-1]}}, b});
    assign d_x    = $signed({{(PW-DATA_W){d[DATA_W-1]}}, d});
    assign prod   = a * b;
    assign prod_x = $signed({prod[2*DATA_W-1], prod});
    // Arithmetic shift gives floor rounding of the fixed-point product.
    assign prod_sh = prod_x >>> FRAC_W;
    assign sum     = a_x + b_x;
    assign diff    = a_x - b_x;
    assign mac     = d_x + prod_sh;
    assign sig     = (a_x >>> 2) + HALF;

    function automatic logic [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAXV) return MAXV[DATA_W-1:0];
        if (v < MINV) return MINV[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    always_comb begin
        alu = '0;
        case (op)
            4'h1: alu = sat(sum);
            4'h2: alu = sat(diff);
            4'h3: alu = sat(prod_sh);
            4'h4: alu = a[DATA_W-1] ? '0 : a;
            4'h5: alu = (!a[DATA_W-1] && a != '0) ? ONE[DATA_W-1:0] : '0;
            4'h6: begin
                if (sig < 0)        alu = '0;
                else if (sig > ONE) alu = ONE[DATA_W-1:0];
                else                alu = sig[DATA_W-1:0];
            end
            4'h7: alu = sat(mac);
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = (halt || illegal) ? S_DONE : S_WB;
            S_WB:    state_d = (pc_q == LAST) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rdata_q <= rf[bus.reg_addr];
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        pc_q  <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_FETCH: ir_q <= prog_mem[pc_q];
                S_EXEC: begin
                    res_q   <= alu;
                    wb_en_q <= writes;
                    if (illegal) err_q <= 1'b1;
                end
                S_WB: begin
                    // No wrap past the last word: that is a runaway program.
                    if (pc_q == LAST) err_q <= 1'b1;
                    else              pc_q  <= pc_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Host and core never write in the same cycle: host only in IDLE.
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = bus.reg_addr;
        rf_wdata = bus.reg_wdata;
        if (state_q == S_WB && wb_en_q) begin
            rf_we    = 1'b1;
            rf_waddr = dst;
            rf_wdata = res_q;
        end else if (state_q == S_IDLE && bus.reg_we) begin
            rf_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state_q == S_IDLE && bus.prog_we)
            prog_mem[bus.prog_addr] <= bus.prog_data;
        if (!reset && rf_we)
            rf[rf_waddr] <= rf_wdata;
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
    assign bus.reg_rdata = rdata_q;
endmodule

// File: tb/tb_ae_seq_core.sv
// Self-checking bench for ae_seq_core: instruction-level reference model,
// per-cycle handshake compare and hand-computed literal results.
module tb_ae_seq_core;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ae_seq_core_if #(.DATA_W(16), .PROG_DEPTH(64)) bus ();

    ae_seq_core #(.DATA_W(16), .FRAC_W(8), .PROG_DEPTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mrf   [16];
    logic [15:0] mprog [64];

    int exp_t   = 0;
    bit exp_err = 1'b0;
    bit active  = 1'b0;
    int edges   = 0;
    int e0      = 0;

    always @(posedge clock) edges++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int s1,
                                        input int s2, input int d);
        return {op[3:0], s1[3:0], s2[3:0], d[3:0]};
    endfunction

    function automatic logic [15:0] sat(input int v);
        logic [31:0] w;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        w = v;
        return w[15:0];
    endfunction

    // Instruction-level interpreter: updates mrf, returns done cycle and err.
    task automatic model_run(output int t, output bit e);
        logic [15:0] w;
        int op, a, b, d, r;
        e = 1'b0;
        for (int pc = 0; pc < 64; pc++) begin
            w  = mprog[pc];
            op = int'(w[15:12]);
            a  = int'($signed(mrf[w[11:8]]));
            b  = int'($signed(mrf[w[7:4]]));
            d  = int'($signed(mrf[w[3:0]]));
            if (op == 15) begin
                t = 3 * pc + 3;
                return;
            end
            if (op >= 8) begin
                e = 1'b1;
                t = 3 * pc + 3;
                return;
            end
            r = 0;
            case (op)
                1: r = a + b;
                2: r = a - b;
                3: r = (a * b) >>> 8;
                4: r = (a < 0) ? 0 : a;
                5: r = (a > 0) ? 256 : 0;
                6: begin
                    r = (a >>> 2) + 128;
                    if (r < 0)   r = 0;
                    if (r > 256) r = 256;
                end
                7: r = d + ((a * b) >>> 8);
                default: r = 0;
            endcase
            if (op != 0) mrf[w[3:0]] = sat(r);
        end
        e = 1'b1;
        t = 3 * 63 + 4;
    endtask

    // Per-cycle handshake compare against the model's timeline.
    always @(negedge clock) begin
        int c;
        c = edges - e0 + 1;
        if (active && c <= exp_t) begin
            check("busy", bus.busy, 1);
            check("done", bus.done, (c == exp_t));
            check("err", bus.err, (c == exp_t) ? exp_err : 1'b0);
        end else if (active && c == exp_t + 1) begin
            check("busy_end", bus.busy, 0);
            check("done_end", bus.done, 0);
            check("err_hold", bus.err, exp_err);
        end
    end

    task automatic wreg(input int r, input logic [15:0] v);
        @(posedge clock); #1;
        bus.reg_we    = 1'b1;
        bus.reg_addr  = r[3:0];
        bus.reg_wdata = v;
        @(posedge clock); #1;
        bus.reg_we = 1'b0;
        mrf[r] = v;
    endtask

    task automatic wprog(input int ad, input logic [15:0] v);
        @(posedge clock); #1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = ad[5:0];
        bus.prog_data = v;
        @(posedge clock); #1;
        bus.prog_we = 1'b0;
        mprog[ad] = v;
    endtask

    task automatic read_reg(input int r, output logic [15:0] v);
        @(posedge clock); #1;
        bus.reg_addr = r[3:0];
        @(posedge clock);
        @(negedge clock);
        v = bus.reg_rdata;
    endtask

    task automatic lit(input string name, input int r, input logic [15:0] v);
        logic [15:0] got;
        read_reg(r, got);
        check({name, "_dut"}, got, v);
        check({name, "_model"}, mrf[r], v);
    endtask

    task automatic cmp_all(input string tag);
        logic [15:0] got;
        for (int r = 0; r < 16; r++) begin
            read_reg(r, got);
            check($sformatf("%s_r%0d", tag, r), got, mrf[r]);
        end
    endtask

    task automatic run(input bit poke);
        model_run(exp_t, exp_err);
        @(posedge clock); #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        e0 = edges;
        active = 1'b1;
        for (int k = 0; k < exp_t + 2; k++) begin
            if (poke && k == 1) begin
                bus.start     = 1'b1;
                bus.reg_we    = 1'b1;
                bus.reg_addr  = 4'd1;
                bus.reg_wdata = 16'hAAAA;
                bus.prog_we   = 1'b1;
                bus.prog_addr = 6'd1;
                bus.prog_data = ins(1, 1, 1, 4);
            end
            @(posedge clock); #1;
            bus.start   = 1'b0;
            bus.reg_we  = 1'b0;
            bus.prog_we = 1'b0;
        end
        active = 1'b0;
    endtask

    initial begin
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.start     = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rdata", bus.reg_rdata, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int r = 0; r < 16; r++) wreg(r, 16'h0000);

        // Q8.8 arithmetic
        wreg(1, 16'h0180);
        wreg(2, 16'h0200);
        wprog(0, ins(3, 1, 2, 3));
        wprog(1, ins(1, 3, 1, 4));
        wprog(2, ins(15, 0, 0, 0));
        run(0);
        check("t1_done_cycle", exp_t, 9);
        lit("t1_r3", 3, 16'h0300);
        lit("t1_r4", 4, 16'h0480);

        // Saturation
        wreg(1, 16'h7F00);
        wreg(2, 16'h0200);
        wprog(0, ins(1, 1, 2, 3));
        wprog(1, ins(3, 1, 1, 4));
        wprog(2, ins(15, 0, 0, 0));
        run(0);
        lit("sat_add", 3, 16'h7FFF);
        lit("sat_mul", 4, 16'h7FFF);
        wreg(1, 16'h8100);
        wprog(0, ins(2, 1, 2, 5));
        wprog(1, ins(15, 0, 0, 0));
        run(0);
        lit("sat_sub", 5, 16'h8000);

        // Activations
        wreg(1, 16'h0000);
        wreg(2, 16'h0400);
        wreg(3, 16'hFF00);
        wreg(4, 16'hFFFF);
        wreg(5, 16'h0001);
        wprog(0, ins(6, 1, 0, 6));
        wprog(1, ins(6, 2, 0, 7));
        wprog(2, ins(6, 3, 0, 8));
        wprog(3, ins(6, 4, 0, 9));
        wprog(4, ins(4, 3, 0, 10));
        wprog(5, ins(5, 5, 0, 11));
        wprog(6, ins(5, 1, 0, 12));
        wprog(7, ins(4, 2, 0, 13));
        wprog(8, ins(15, 0, 0, 0));
        run(0);
        lit("sigm_0", 6, 16'h0080);
        lit("sigm_4", 7, 16'h0100);
        lit("sigm_m1", 8, 16'h0040);
        lit("sigm_lsb", 9, 16'h007F);
        lit("relu_neg", 10, 16'h0000);
        lit("relud_pos", 11, 16'h0100);
        lit("relud_0", 12, 16'h0000);
        lit("relu_pos", 13, 16'h0400);
        cmp_all("act");

        // MAC chain
        wreg(5, 16'h0100);
        wreg(1, 16'h0200);
        wreg(2, 16'h0080);
        wreg(6, 16'h0100);
        wprog(0, ins(7, 1, 6, 5));
        wprog(1, ins(15, 0, 0, 0));
        run(0);
        lit("mac_1", 5, 16'h0300);
        run(0);
        lit("mac_2", 5, 16'h0500);
        wreg(7, 16'h0000);
        wreg(8, 16'h7F00);
        wreg(9, 16'h0000);
        wreg(3, 16'hFF00);
        wreg(11, 16'hFFFF);
        wprog(0, ins(7, 1, 2, 7));
        wprog(1, ins(7, 8, 1, 8));
        wprog(2, ins(7, 3, 1, 9));
        wprog(3, ins(3, 11, 2, 10));
        wprog(4, ins(15, 0, 0, 0));
        run(0);
        lit("mac_half", 7, 16'h0100);
        lit("mac_ovf", 8, 16'h7FFF);
        lit("mac_neg", 9, 16'hFE00);
        lit("mul_floor", 10, 16'hFFFF);

        // Illegal opcode at index 2
        wreg(12, 16'h1234);
        wreg(13, 16'h4321);
        wprog(0, ins(1, 1, 1, 10));
        wprog(1, ins(1, 2, 2, 11));
        wprog(2, ins(9, 1, 1, 12));
        wprog(3, ins(1, 1, 1, 13));
        wprog(4, ins(15, 0, 0, 0));
        run(0);
        check("ill_done_cycle", exp_t, 9);
        check("ill_err_model", exp_err, 1);
        lit("ill_nowb", 12, 16'h1234);
        lit("ill_stop", 13, 16'h4321);

        // Next start clears err
        wprog(0, ins(15, 0, 0, 0));
        run(0);

        // Host activity during busy is dropped
        wprog(0, ins(1, 1, 2, 3));
        wprog(1, ins(15, 0, 0, 0));
        run(1);
        cmp_all("poke");

        // Program without HALT runs off the end
        for (int i = 0; i < 64; i++) wprog(i, 16'h0000);
        run(0);
        check("runoff_cycle", exp_t, 193);

        // Reset during EXEC
        wreg(14, 16'h5555);
        wprog(0, ins(1, 1, 1, 14));
        wprog(1, ins(15, 0, 0, 0));
        @(posedge clock); #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rx_busy", bus.busy, 0);
        check("rx_done", bus.done, 0);
        check("rx_err", bus.err, 0);
        check("rx_rdata", bus.reg_rdata, 0);
        repeat (4) @(posedge clock);
        lit("rx_keep", 14, 16'h5555);
        run(0);
        cmp_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
